// File: rtl/bram_chunk_reader.sv
// Reads a chunk of words out of the shared BRAM and streams it as an AXI4-Stream master.
// A 2-entry buffer absorbs the 1-cycle BRAM latency and downstream backpressure.
module bram_chunk_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  m00_axis_aclk,
  input  logic                  m00_axis_aresetn,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] len_m1,
  output logic                  bram_en,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  input  logic [DATA_WIDTH-1:0] bram_rdata,
  output logic [DATA_WIDTH-1:0] m00_axis_tdata,
  output logic                  m00_axis_tvalid,
  input  logic                  m00_axis_tready,
  output logic                  m00_axis_tlast,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  localparam logic [ADDR_WIDTH:0] CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_t state, state_next;

  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH-1:0] len_q;
  logic [ADDR_WIDTH:0]   issue_cnt;
  logic [ADDR_WIDTH:0]   send_cnt;
  logic [ADDR_WIDTH:0]   chunk_len;
  logic                  inflight;
  logic [1:0]            count;
  logic [DATA_WIDTH-1:0] buf_data [2];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic                  pop;
  logic                  push;
  logic                  issue;
  logic                  last_issue;
  logic                  last_pop;
  logic [2:0]            occupancy;

  assign chunk_len = {1'b0, len_q} + CNT_ONE;
  assign occupancy = {1'b0, count} + {2'b00, inflight};
  assign pop       = m00_axis_tvalid & m00_axis_tready;
  assign push      = inflight;

  // A read is only issued if its word is guaranteed a buffer slot when it returns.
  assign issue      = (state == READ) && (issue_cnt != chunk_len) &&
                      (occupancy < (pop ? 3'd3 : 3'd2));
  assign last_issue = issue && ((issue_cnt + CNT_ONE) == chunk_len);
  assign last_pop   = pop && (send_cnt == {1'b0, len_q});

  assign m00_axis_tvalid = (count != 2'd0);
  assign m00_axis_tdata  = buf_data[rd_ptr];
  assign m00_axis_tlast  = m00_axis_tvalid && (send_cnt == {1'b0, len_q});
  assign bram_addr       = base_q + issue_cnt[ADDR_WIDTH-1:0];

  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = READ;
      READ:    if (last_issue) state_next = DRAIN;
      DRAIN:   if (last_pop) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bram_en = issue;
    busy    = (state == READ) || (state == DRAIN);
    done    = (state == DONE);
  end

  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      base_q      <= '0;
      len_q       <= '0;
      issue_cnt   <= '0;
      send_cnt    <= '0;
      inflight    <= 1'b0;
      count       <= 2'd0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      buf_data[0] <= '0;
      buf_data[1] <= '0;
    end else begin
      if ((state == IDLE) && start) begin
        base_q    <= base_addr;
        len_q     <= len_m1;
        issue_cnt <= '0;
        send_cnt  <= '0;
      end else begin
        if (issue) issue_cnt <= issue_cnt + CNT_ONE;
        if (pop)   send_cnt  <= send_cnt + CNT_ONE;
      end
      inflight <= issue;
      if (push) begin
        buf_data[wr_ptr] <= bram_rdata;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule
